// File: rtl/max_reduce_stream_pkg.sv
// Shared max-plus semiring types for the streaming max-reduction engine.
// The MAXRED_ARGIDX_EN macro sizes the optional winner-index field via MR_IDXW.
package semiring_pkg;

    localparam int SR_W    = 16;
    localparam int MR_N    = 16;
    localparam int MR_IDXW = $clog2(MR_N);

    typedef logic [SR_W-1:0] sr_elem_t;

    typedef enum logic {
        MR_IDLE = 1'b0,
        MR_ACC  = 1'b1
    } mr_state_t;

    // Earlier operand wins ties so the lowest index is kept.
    function automatic sr_elem_t sr_max(input sr_elem_t a, input sr_elem_t b);
        sr_elem_t r;
        if (a >= b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/max_reduce_stream_if.sv
// Input beat / output result handshake bundle for max_reduce_stream.
// The out_idx signal exists only when MAXRED_ARGIDX_EN is defined.
interface max_reduce_stream_if
    import semiring_pkg::*;
#(
    parameter int W = SR_W
);
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
`ifdef MAXRED_ARGIDX_EN
    logic [MR_IDXW-1:0]  out_idx;
`endif

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
`ifdef MAXRED_ARGIDX_EN
        , output out_idx
`endif
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
`ifdef MAXRED_ARGIDX_EN
        , input out_idx
`endif
    );

endinterface

// File: rtl/max_reduce_stream_max2_sel.sv
// Two-input unsigned compare/select; o_take_b (MAXRED_ARGIDX_EN only) flags a strict win of i_b.
module max2_sel #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_max
`ifdef MAXRED_ARGIDX_EN
    ,
    output logic         o_take_b
`endif
);

    logic w_take_b;

    // Strict compare keeps i_a on ties.
    always_comb begin
        w_take_b = (i_b > i_a);
        if (w_take_b) begin
            o_max = i_b;
        end else begin
            o_max = i_a;
        end
    end

`ifdef MAXRED_ARGIDX_EN
    assign o_take_b = w_take_b;
`endif

endmodule

// File: rtl/max_reduce_stream.sv
// Streaming max-reduction: folds groups of up to N beats into their maximum, one result per group.
// Define MAXRED_ARGIDX_EN to also track and emit the winning beat index on out_idx.
module max_reduce_stream
    import semiring_pkg::*;
#(
    parameter int W = SR_W,
    parameter int N = MR_N
) (
    input  logic              clk,
    input  logic              rst_n,
    max_reduce_stream_if.slave bus
);

    localparam int              IDXW     = $clog2(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    mr_state_t        r_state;
    logic [W-1:0]     r_acc;
    logic [IDXW-1:0]  r_cnt;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_close;
    logic [W-1:0]     w_base;
    logic [W-1:0]     w_win;

`ifdef MAXRED_ARGIDX_EN
    logic [IDXW-1:0]  r_aidx;
    logic [IDXW-1:0]  r_out_idx;
    logic [IDXW-1:0]  w_win_idx;
    logic             w_take_b;
`endif

    // Handshake and close detection; the first beat of a group is compared against itself.
    always_comb begin
        w_in_ready = !(r_out_valid && !bus.out_ready);
        w_accept   = bus.in_valid && w_in_ready;
        w_close    = w_accept && (bus.in_last || (r_cnt == LAST_IDX));
        if (r_state == MR_IDLE) begin
            w_base = bus.in_data;
        end else begin
            w_base = r_acc;
        end
    end

    max2_sel #(.W(W)) u_max2 (
        .i_a      (w_base),
        .i_b      (bus.in_data),
        .o_max    (w_win)
`ifdef MAXRED_ARGIDX_EN
        ,
        .o_take_b (w_take_b)
`endif
    );

`ifdef MAXRED_ARGIDX_EN
    // Winner index: restart at 0 for a new group, move only on a strict win.
    always_comb begin
        if (r_state == MR_IDLE) begin
            w_win_idx = {IDXW{1'b0}};
        end else if (w_take_b) begin
            w_win_idx = r_cnt;
        end else begin
            w_win_idx = r_aidx;
        end
    end
`endif

    // Group FSM, beat counter, accumulator and output result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= MR_IDLE;
            r_acc       <= {W{1'b0}};
            r_cnt       <= {IDXW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_data  <= {W{1'b0}};
`ifdef MAXRED_ARGIDX_EN
            r_aidx      <= {IDXW{1'b0}};
            r_out_idx   <= {IDXW{1'b0}};
`endif
        end else begin
            if (w_close) begin
                r_state     <= MR_IDLE;
                r_cnt       <= {IDXW{1'b0}};
                r_out_valid <= 1'b1;
                r_out_data  <= w_win;
`ifdef MAXRED_ARGIDX_EN
                r_out_idx   <= w_win_idx;
`endif
            end else begin
                if (w_accept) begin
                    r_state <= MR_ACC;
                    r_acc   <= w_win;
                    r_cnt   <= r_cnt + IDXW'(1);
`ifdef MAXRED_ARGIDX_EN
                    r_aidx  <= w_win_idx;
`endif
                end
                // A taken result is dropped unless a new close beat replaces it above.
                if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
`ifdef MAXRED_ARGIDX_EN
    assign bus.out_idx   = r_out_idx;
`endif

endmodule
